// File: rtl/rs_chien_seq_if.sv
// Signal bundle around the Chien search sequencer: locator intake, evaluator request/response
// and the compacted error-position result towards the Forney stage.
interface rs_chien_seq_if #(
  parameter int SYMB_WIDTH      = 8,
  parameter int T_LEN           = 8,
  parameter int ROOTS_PER_CYCLE = 16
);
  localparam int LOC_W = (T_LEN + 1) * SYMB_WIDTH;
  localparam int CNT_W = $clog2(T_LEN + 1);

  logic [LOC_W-1:0]            loc_i;
  logic                        loc_vld_i;
  logic                        loc_rdy_o;
  logic                        flush_i;
  logic [LOC_W-1:0]            eval_loc_o;
  logic [SYMB_WIDTH-1:0]       eval_base_o;
  logic                        eval_vld_o;
  logic [ROOTS_PER_CYCLE-1:0]  eval_hit_i;
  logic [T_LEN*SYMB_WIDTH-1:0] pos_o;
  logic [T_LEN-1:0]            pos_mask_o;
  logic [CNT_W-1:0]            pos_cnt_o;
  logic                        pos_vld_o;
  logic                        pos_rdy_i;
  logic                        rs_chien_err;

  modport slave (
    input  loc_i, loc_vld_i, flush_i, eval_hit_i, pos_rdy_i,
    output loc_rdy_o, eval_loc_o, eval_base_o, eval_vld_o,
           pos_o, pos_mask_o, pos_cnt_o, pos_vld_o, rs_chien_err
  );

  modport master (
    output loc_i, loc_vld_i, flush_i, eval_hit_i, pos_rdy_i,
    input  loc_rdy_o, eval_loc_o, eval_base_o, eval_vld_o,
           pos_o, pos_mask_o, pos_cnt_o, pos_vld_o, rs_chien_err
  );
endinterface

// File: rtl/rs_chien_seq.sv
// Multicycle Chien search sequencer: holds one locator, sweeps root exponents chunk by chunk
// through an external evaluator and compacts the returned hits into error positions.
module rs_chien_seq #(
  parameter int SYMB_WIDTH      = 8,
  parameter int T_LEN           = 8,
  parameter int ROOTS_PER_CYCLE = 16,
  parameter int EVAL_LAT        = 1
) (
  input logic           aclk,
  input logic           aresetn,
  rs_chien_seq_if.slave bus
);
  localparam int N_ROOTS = (1 << SYMB_WIDTH) - 1;
  localparam int CYCLES  = (N_ROOTS + ROOTS_PER_CYCLE - 1) / ROOTS_PER_CYCLE;
  localparam int CH_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int LOC_W   = (T_LEN + 1) * SYMB_WIDTH;
  localparam int POS_W   = T_LEN * SYMB_WIDTH;
  localparam int SLOT_W  = $clog2(T_LEN + 1);
  localparam int RAW_W   = $clog2(T_LEN + 2);
  localparam logic [SYMB_WIDTH-1:0] BASE_STEP  = SYMB_WIDTH'(ROOTS_PER_CYCLE);
  localparam logic [CH_W-1:0]       LAST_CHUNK = CH_W'(CYCLES - 1);
  localparam logic [RAW_W-1:0]      RAW_SAT    = RAW_W'(T_LEN + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_loc_rdy;
  logic [LOC_W-1:0]      r_loc;
  logic [RAW_W-1:0]      r_deg;
  logic                  r_zero;
  logic [CH_W-1:0]       r_cntr;
  logic [SYMB_WIDTH-1:0] r_eval_base;
  logic                  r_eval_vld;
  logic                  r_pos_vld;
  logic                  r_err;
  logic [POS_W-1:0]      r_pos;
  logic [T_LEN-1:0]      r_mask;
  logic [SLOT_W-1:0]     r_cnt;
  logic [RAW_W-1:0]      r_raw;
  logic                  r_ovf;

  logic                  w_accept;
  logic                  w_issue_last;
  logic                  w_cap_vld;
  logic                  w_cap_last;
  logic [SYMB_WIDTH-1:0] w_cap_base;
  logic [RAW_W-1:0]      w_deg;
  logic                  w_zero;
  logic [POS_W-1:0]      w_pos_n;
  logic [T_LEN-1:0]      w_mask_n;
  logic [SLOT_W-1:0]     w_cnt_n;
  logic [RAW_W-1:0]      w_raw_n;
  logic                  w_ovf_n;
  logic                  w_err_n;

  assign w_accept     = (r_state == IDLE) && bus.loc_vld_i;
  assign w_issue_last = (r_cntr == LAST_CHUNK);

  // Delay line aligning each issued chunk's valid/base/last with the evaluator's hit response
  generate
    if (EVAL_LAT == 0) begin : g_no_lat
      assign w_cap_vld  = r_eval_vld;
      assign w_cap_base = r_eval_base;
      assign w_cap_last = r_eval_vld && w_issue_last;
    end else begin : g_lat
      logic [EVAL_LAT-1:0]                 r_dl_vld;
      logic [EVAL_LAT-1:0]                 r_dl_last;
      logic [EVAL_LAT-1:0][SYMB_WIDTH-1:0] r_dl_base;

      // Shift register of outstanding chunk requests, wiped by abort
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          r_dl_vld  <= '0;
          r_dl_last <= '0;
          r_dl_base <= '0;
        end else if (bus.flush_i) begin
          r_dl_vld  <= '0;
          r_dl_last <= '0;
          r_dl_base <= '0;
        end else begin
          r_dl_vld[0]  <= r_eval_vld;
          r_dl_last[0] <= r_eval_vld && w_issue_last;
          r_dl_base[0] <= r_eval_base;
          for (int k = 1; k < EVAL_LAT; k++) begin
            r_dl_vld[k]  <= r_dl_vld[k-1];
            r_dl_last[k] <= r_dl_last[k-1];
            r_dl_base[k] <= r_dl_base[k-1];
          end
        end
      end

      assign w_cap_vld  = r_dl_vld[EVAL_LAT-1];
      assign w_cap_last = r_dl_vld[EVAL_LAT-1] && r_dl_last[EVAL_LAT-1];
      assign w_cap_base = r_dl_base[EVAL_LAT-1];
    end
  endgenerate

  // Locator degree: index of the highest nonzero coefficient, all-zero flagged separately
  always_comb begin
    w_deg  = '0;
    w_zero = 1'b1;
    for (int k = 0; k <= T_LEN; k++) begin
      if (bus.loc_i[k*SYMB_WIDTH +: SYMB_WIDTH] != '0) begin
        w_deg  = RAW_W'(k);
        w_zero = 1'b0;
      end else begin
        w_deg  = w_deg;
      end
    end
  end

  // Append the captured chunk's hits in ascending exponent order; tail exponents >= N are ignored
  always_comb begin
    w_pos_n  = r_pos;
    w_mask_n = r_mask;
    w_cnt_n  = r_cnt;
    w_raw_n  = r_raw;
    w_ovf_n  = r_ovf;
    if (w_cap_vld) begin
      for (int i = 0; i < ROOTS_PER_CYCLE; i++) begin
        if (bus.eval_hit_i[i] && ((int'(w_cap_base) + i) < N_ROOTS)) begin
          if (int'(w_cnt_n) < T_LEN) begin
            w_pos_n[int'(w_cnt_n)*SYMB_WIDTH +: SYMB_WIDTH] = w_cap_base + SYMB_WIDTH'(i);
            w_mask_n[int'(w_cnt_n)] = 1'b1;
            w_cnt_n = w_cnt_n + SLOT_W'(1);
          end else begin
            w_ovf_n = 1'b1;
          end
          if (w_raw_n != RAW_SAT) begin
            w_raw_n = w_raw_n + RAW_W'(1);
          end else begin
            w_raw_n = w_raw_n;
          end
        end else begin
          w_ovf_n = w_ovf_n;
        end
      end
    end else begin
      w_ovf_n = r_ovf;
    end
  end

  assign w_err_n = r_zero || w_ovf_n || (w_raw_n != r_deg);

  // Position accumulators: cleared on abort or new locator, updated while hits can arrive
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_pos  <= '0;
      r_mask <= '0;
      r_cnt  <= '0;
      r_raw  <= '0;
      r_ovf  <= 1'b0;
    end else if (bus.flush_i || w_accept) begin
      r_pos  <= '0;
      r_mask <= '0;
      r_cnt  <= '0;
      r_raw  <= '0;
      r_ovf  <= 1'b0;
    end else if ((r_state == SEARCH) || (r_state == DRAIN)) begin
      r_pos  <= w_pos_n;
      r_mask <= w_mask_n;
      r_cnt  <= w_cnt_n;
      r_raw  <= w_raw_n;
      r_ovf  <= w_ovf_n;
    end else begin
      r_ovf  <= r_ovf;
    end
  end

  // Sequencer FSM with registered handshake, evaluator request and result-valid outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_loc_rdy   <= 1'b1;
      r_loc       <= '0;
      r_deg       <= '0;
      r_zero      <= 1'b0;
      r_cntr      <= '0;
      r_eval_base <= '0;
      r_eval_vld  <= 1'b0;
      r_pos_vld   <= 1'b0;
      r_err       <= 1'b0;
    end else if (bus.flush_i) begin
      r_state     <= IDLE;
      r_loc_rdy   <= 1'b1;
      r_cntr      <= '0;
      r_eval_base <= '0;
      r_eval_vld  <= 1'b0;
      r_pos_vld   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.loc_vld_i) begin
            r_loc       <= bus.loc_i;
            r_deg       <= w_deg;
            r_zero      <= w_zero;
            r_cntr      <= '0;
            r_eval_base <= '0;
            r_eval_vld  <= 1'b1;
            r_loc_rdy   <= 1'b0;
            r_err       <= 1'b0;
            r_state     <= SEARCH;
          end else begin
            r_loc_rdy   <= 1'b1;
          end
        end
        SEARCH: begin
          // With zero evaluator latency the last chunk is captured on its own issue edge
          if (w_cap_last) begin
            r_eval_vld <= 1'b0;
            r_pos_vld  <= 1'b1;
            r_err      <= w_err_n;
            r_state    <= DONE;
          end else if (w_issue_last) begin
            r_eval_vld <= 1'b0;
            r_state    <= DRAIN;
          end else begin
            r_cntr      <= r_cntr + CH_W'(1);
            r_eval_base <= r_eval_base + BASE_STEP;
          end
        end
        DRAIN: begin
          if (w_cap_last) begin
            r_pos_vld <= 1'b1;
            r_err     <= w_err_n;
            r_state   <= DONE;
          end else begin
            r_state   <= DRAIN;
          end
        end
        DONE: begin
          if (bus.pos_rdy_i) begin
            r_pos_vld <= 1'b0;
            r_loc_rdy <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_state   <= DONE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_loc_rdy  <= 1'b1;
          r_eval_vld <= 1'b0;
          r_pos_vld  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.loc_rdy_o    = r_loc_rdy;
  assign bus.eval_loc_o   = r_loc;
  assign bus.eval_base_o  = r_eval_base;
  assign bus.eval_vld_o   = r_eval_vld;
  assign bus.pos_o        = r_pos;
  assign bus.pos_mask_o   = r_mask;
  assign bus.pos_cnt_o    = r_cnt;
  assign bus.pos_vld_o    = r_pos_vld;
  assign bus.rs_chien_err = r_err;

endmodule
